// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters: round-robin grant with a
// bounded lock for back-to-back sequences, and a single registered response stage.
module alu_share_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int DATA_W   = 8,
   parameter int SEL_W    = 4,
   parameter int MAX_LOCK = 4,
   parameter int ID_W     = $clog2(NUM_REQ)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [NUM_REQ-1:0]          req_lock,
   input  logic [NUM_REQ*SEL_W-1:0]    req_sel,
   input  logic [NUM_REQ*DATA_W-1:0]   req_a,
   input  logic [NUM_REQ*DATA_W-1:0]   req_b,
   output logic [DATA_W-1:0]           alu_in0,
   output logic [DATA_W-1:0]           alu_in1,
   output logic [SEL_W-1:0]            alu_select,
   input  logic [DATA_W-1:0]           alu_result,
   input  logic                        alu_carry,
   input  logic                        alu_compare,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [ID_W-1:0]             rsp_id,
   output logic [DATA_W-1:0]           rsp_data,
   output logic                        rsp_carry,
   output logic                        rsp_compare
);

   localparam int RUN_W = $clog2(MAX_LOCK + 1);
   localparam logic [SEL_W-1:0] SEL_IDLE = SEL_W'(13);

   typedef enum logic {ARB, LOCKED} state_t;

   state_t            state_q;
   logic [ID_W-1:0]   rr_ptr_q;
   logic [ID_W-1:0]   own_q;
   logic [RUN_W-1:0]  run_q;

   logic              can_issue;
   logic              arb_mode;
   logic              grant_vld;
   logic [ID_W-1:0]   grant_id;
   logic [ID_W-1:0]   next_ptr;
   logic [RUN_W-1:0]  run_cnt;
   logic              keep_lock;

   assign can_issue = rst_n && (!rsp_valid || rsp_ready);

   // An idle, unlocked owner releases the lock in the same cycle.
   assign arb_mode = (state_q == ARB) || (!req_valid[own_q] && !req_lock[own_q]);

   always_comb begin : grant_select
      int idx;
      // NOTE: every combinational output gets a default first, so no path leaves
      // it unassigned and no latch is inferred.
      grant_vld = 1'b0;
      grant_id  = '0;
      idx       = 0;
      if (can_issue) begin
         if (!arb_mode) begin
            grant_vld = req_valid[own_q];
            grant_id  = own_q;
         end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
               idx = (int'(rr_ptr_q) + i) % NUM_REQ;
               if (!grant_vld && req_valid[idx]) begin
                  grant_vld = 1'b1;
                  grant_id  = ID_W'(idx);
               end
            end
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (grant_vld) req_ready[grant_id] = 1'b1;
   end

   assign alu_in0    = grant_vld ? req_a[grant_id*DATA_W +: DATA_W]  : '0;
   assign alu_in1    = grant_vld ? req_b[grant_id*DATA_W +: DATA_W]  : '0;
   assign alu_select = grant_vld ? req_sel[grant_id*SEL_W +: SEL_W] : SEL_IDLE;

   assign run_cnt   = (state_q == LOCKED && grant_id == own_q) ? run_q + 1'b1 : RUN_W'(1);
   assign keep_lock = req_lock[grant_id] && (run_cnt < RUN_W'(MAX_LOCK));
   assign next_ptr  = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ARB;
         rr_ptr_q    <= '0;
         own_q       <= '0;
         run_q       <= '0;
         rsp_valid   <= 1'b0;
         rsp_id      <= '0;
         rsp_data    <= '0;
         rsp_carry   <= 1'b0;
         rsp_compare <= 1'b0;
      end else begin
         if (grant_vld) begin
            rsp_valid   <= 1'b1;
            rsp_id      <= grant_id;
            rsp_data    <= alu_result;
            rsp_carry   <= alu_carry;
            rsp_compare <= alu_compare;
            if (keep_lock) begin
               state_q <= LOCKED;
               own_q   <= grant_id;
               run_q   <= run_cnt;
            end else begin
               state_q  <= ARB;
               run_q    <= '0;
               rr_ptr_q <= next_ptr;
            end
         end else begin
            if (rsp_ready) rsp_valid <= 1'b0;
            if (state_q == LOCKED && arb_mode) begin
               state_q <= ARB;
               run_q   <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU model on the ALU port.
module tb_alu_share_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int SW = 4;
   localparam int ML = 3;
   localparam int IW = 2;

   logic              clk;
   logic              rst_n;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_ready;
   logic [N-1:0]      req_lock;
   logic [N*SW-1:0]   req_sel;
   logic [N*DW-1:0]   req_a;
   logic [N*DW-1:0]   req_b;
   logic [DW-1:0]     alu_in0;
   logic [DW-1:0]     alu_in1;
   logic [SW-1:0]     alu_select;
   logic [DW-1:0]     alu_result;
   logic              alu_carry;
   logic              alu_compare;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IW-1:0]     rsp_id;
   logic [DW-1:0]     rsp_data;
   logic              rsp_carry;
   logic              rsp_compare;
   logic [DW:0]       sum9;

   int tests = 0;
   int fails = 0;

   alu_share_arbiter #(
      .NUM_REQ(N), .DATA_W(DW), .SEL_W(SW), .MAX_LOCK(ML), .ID_W(IW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_lock(req_lock),
      .req_sel(req_sel), .req_a(req_a), .req_b(req_b),
      .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_select(alu_select),
      .alu_result(alu_result), .alu_carry(alu_carry), .alu_compare(alu_compare),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_compare(rsp_compare)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ALU model: 0 add, 1 and, 2 sub, 3 or, 4 xor, 5 shl, 6 inc, 7 dec, 13 pass a.
   always_comb begin
      sum9        = {1'b0, alu_in0} + {1'b0, alu_in1};
      alu_result  = '0;
      alu_carry   = 1'b0;
      case (alu_select)
         4'd0:  begin alu_result = sum9[DW-1:0]; alu_carry = sum9[DW]; end
         4'd1:  alu_result = alu_in0 & alu_in1;
         4'd2:  alu_result = alu_in0 - alu_in1;
         4'd3:  alu_result = alu_in0 | alu_in1;
         4'd4:  alu_result = alu_in0 ^ alu_in1;
         4'd5:  alu_result = alu_in0 << 1;
         4'd6:  alu_result = alu_in0 + 8'd1;
         4'd7:  alu_result = alu_in0 - 8'd1;
         4'd13: alu_result = alu_in0;
         default: alu_result = '0;
      endcase
      alu_compare = (alu_in0 == alu_in1);
   end

   // Requester i: add, a = 16*i+1, b = i, so its sum is 17*i+1.
   task automatic set_ops();
      for (int i = 0; i < N; i++) begin
         req_sel[i*SW +: SW] = 4'd0;
         req_a[i*DW +: DW]   = 8'(16 * i + 1);
         req_b[i*DW +: DW]   = 8'(i);
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      rsp_ready = 1'b1;
      req_lock  = '0;
      req_valid = 4'hF;
      set_ops();
      #12;
      tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
      tests++; if (rsp_id !== 2'd0) begin fails++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
      tests++; if (rsp_data !== 8'h00) begin fails++; $display("FAIL reset_rsp_data: got %h want 00", rsp_data); end
      tests++; if ({rsp_carry, rsp_compare} !== 2'b00) begin fails++; $display("FAIL reset_flags: got %b want 00", {rsp_carry, rsp_compare}); end
      tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
      tests++; if (alu_select !== 4'd13) begin fails++; $display("FAIL reset_alu_select: got %0d want 13", alu_select); end
      tests++; if ({alu_in0, alu_in1} !== 16'h0000) begin fails++; $display("FAIL reset_alu_ops: got %h want 0000", {alu_in0, alu_in1}); end
      req_valid = '0;
      #1 rst_n = 1'b1;
   endtask

   task automatic test_single_op();
      @(posedge clk); #1;
      req_sel[2*SW +: SW] = 4'd0;
      req_a[2*DW +: DW]   = 8'hF0;
      req_b[2*DW +: DW]   = 8'h20;
      req_valid = 4'b0100;
      @(negedge clk);
      tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL single_ready: got %b want 0100", req_ready); end
      tests++; if ({alu_select, alu_in0, alu_in1} !== 20'h0F020) begin fails++; $display("FAIL single_alu_drive: got %h want 0f020", {alu_select, alu_in0, alu_in1}); end
      @(posedge clk); #1;
      req_valid = '0;
      tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL single_rsp_valid: got %b want 1", rsp_valid); end
      tests++; if (rsp_id !== 2'd2) begin fails++; $display("FAIL single_rsp_id: got %0d want 2", rsp_id); end
      tests++; if (rsp_data !== 8'h10) begin fails++; $display("FAIL single_rsp_data: got %h want 10", rsp_data); end
      tests++; if ({rsp_carry, rsp_compare} !== 2'b10) begin fails++; $display("FAIL single_flags: got %b want 10", {rsp_carry, rsp_compare}); end
      @(posedge clk); #1;
      tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL single_drain: got %b want 0", rsp_valid); end
   endtask

   task automatic test_round_robin();
      logic [IW-1:0] exp_id;
      set_ops();
      req_valid = 4'b1000;
      @(posedge clk); #1;
      tests++; if (rsp_id !== 2'd3) begin fails++; $display("FAIL rr_align_id: got %0d want 3", rsp_id); end
      req_valid = 4'hF;
      for (int k = 0; k < 6; k++) begin
         exp_id = 2'(k % 4);
         @(posedge clk); #1;
         tests++; if ({rsp_valid, rsp_id} !== {1'b1, exp_id}) begin fails++; $display("FAIL rr_seq0[%0d]: got v=%b id=%0d want v=1 id=%0d", k, rsp_valid, rsp_id, exp_id); end
         tests++; if (rsp_data !== 8'(17 * (k % 4) + 1)) begin fails++; $display("FAIL rr_data[%0d]: got %h want %h", k, rsp_data, 8'(17 * (k % 4) + 1)); end
      end
      req_valid = '0;
      @(posedge clk); #1;
      tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rr_gap: got %b want 0", rsp_valid); end
      req_valid = 4'hF;
      for (int k = 0; k < 4; k++) begin
         exp_id = 2'((k + 2) % 4);
         @(posedge clk); #1;
         tests++; if ({rsp_valid, rsp_id} !== {1'b1, exp_id}) begin fails++; $display("FAIL rr_seq2[%0d]: got v=%b id=%0d want v=1 id=%0d", k, rsp_valid, rsp_id, exp_id); end
      end
   endtask

   task automatic test_backpressure();
      rsp_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL bp_ready[%0d]: got %b want 0000", c, req_ready); end
         tests++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd1, 8'h12}) begin fails++; $display("FAIL bp_hold[%0d]: got v=%b id=%0d d=%h want v=1 id=1 d=12", c, rsp_valid, rsp_id, rsp_data); end
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      #2;
      tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL bp_same_cycle_grant: got %b want 0100", req_ready); end
      @(posedge clk); #1;
      req_valid = '0;
      tests++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd2, 8'h23}) begin fails++; $display("FAIL bp_next_rsp: got v=%b id=%0d d=%h want v=1 id=2 d=23", rsp_valid, rsp_id, rsp_data); end
   endtask

   task automatic test_lock();
      logic [IW-1:0] exp_seq [7] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      req_valid = 4'b0001;
      @(posedge clk); #1;
      tests++; if (rsp_id !== 2'd0) begin fails++; $display("FAIL lock_align_id: got %0d want 0", rsp_id); end
      req_valid = 4'hF;
      req_lock  = 4'b0010;
      for (int k = 0; k < 7; k++) begin
         @(posedge clk); #1;
         tests++; if ({rsp_valid, rsp_id} !== {1'b1, exp_seq[k]}) begin fails++; $display("FAIL lock_seq[%0d]: got v=%b id=%0d want v=1 id=%0d", k, rsp_valid, rsp_id, exp_seq[k]); end
      end
      req_valid = 4'b1101;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL lock_reserve_ready[%0d]: got %b want 0000", c, req_ready); end
         tests++; if ({alu_select, alu_in0, alu_in1} !== 20'hD0000) begin fails++; $display("FAIL lock_reserve_alu[%0d]: got %h want d0000", c, {alu_select, alu_in0, alu_in1}); end
      end
   endtask

   task automatic test_lock_release();
      @(posedge clk); #1;
      req_lock  = '0;
      req_valid = 4'b1000;
      #2;
      tests++; if (req_ready !== 4'b1000) begin fails++; $display("FAIL release_ready: got %b want 1000", req_ready); end
      @(posedge clk); #1;
      tests++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd3, 8'h34}) begin fails++; $display("FAIL release_rsp: got v=%b id=%0d d=%h want v=1 id=3 d=34", rsp_valid, rsp_id, rsp_data); end
   endtask

   task automatic test_reset_mid_lock();
      req_valid = 4'b0001;
      req_lock  = 4'b0001;
      @(posedge clk); #1;
      tests++; if ({rsp_valid, rsp_id} !== {1'b1, 2'd0}) begin fails++; $display("FAIL rml_enter: got v=%b id=%0d want v=1 id=0", rsp_valid, rsp_id); end
      rsp_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rml_rsp_cleared: got %b want 0", rsp_valid); end
      tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL rml_ready_in_reset: got %b want 0000", req_ready); end
      req_valid = 4'b0110;
      rsp_ready = 1'b1;
      #1 rst_n = 1'b1;
      #1;
      tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL rml_first_grant: got %b want 0010", req_ready); end
      @(posedge clk); #1;
      tests++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd1, 8'h12}) begin fails++; $display("FAIL rml_rsp: got v=%b id=%0d d=%h want v=1 id=1 d=12", rsp_valid, rsp_id, rsp_data); end
      req_valid = '0;
      req_lock  = '0;
   endtask

   initial begin
      test_reset();
      test_single_op();
      test_round_robin();
      test_backpressure();
      test_lock();
      test_lock_release();
      test_reset_mid_lock();
      @(posedge clk); #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
